// File: rtl/clk_div_prog_pkg.sv
// Shared constants and FSM state type for the programmable serial clock divider.
package clk_div_prog_pkg;

    localparam logic CLK_CS_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cdp_state_e;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable serial clock generator: runtime half-period, idle polarity, burst or
// continuous mode, glitch-free stop, and lead/trail edge strobes for the shift logic.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | clk_cs parked at cpol, waiting for start with enable
// ST_RUN   | generating periods, enable still asserted
// ST_DRAIN | enable dropped mid-period; finishing the current period only
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_cs_en,
    input  logic               start,
    input  logic [CNT_W-1:0]   div_half,
    input  logic               cpol,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_cs,
    output logic               lead_stb,
    output logic               trail_stb,
    output logic               busy,
    output logic               done
);

    cdp_state_e         state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] periods;
    logic [BURST_W-1:0] periods_inc;
    logic [CNT_W-1:0]   div_half_q;
    logic [BURST_W-1:0] burst_len_q;
    logic               cpol_q;

    logic en;
    logic active;
    logic at_edge;
    logic idle_phase;
    logic lead_ev;
    logic trail_ev;
    logic stop_idle;
    logic last;
    logic launch;

    assign en          = (clk_cs_en == CLK_CS_ENABLE);
    assign busy        = (state != ST_IDLE);
    assign periods_inc = periods + 1'b1;

    always_comb begin
        launch     = 1'b0;
        active     = 1'b0;
        at_edge    = 1'b0;
        idle_phase = (clk_cs == cpol_q);
        lead_ev    = 1'b0;
        trail_ev   = 1'b0;
        stop_idle  = 1'b0;
        last       = 1'b0;
        state_nx   = state;

        case (state)
            ST_IDLE: begin
                if (start && en) begin
                    launch   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // the cycle carrying done is a dead cycle before returning to idle
                active    = !done;
                at_edge   = active && (cnt == div_half_q);
                lead_ev   = at_edge && idle_phase && en;
                // enable gone right before a leading edge: stop without starting a period
                stop_idle = at_edge && idle_phase && !en;
                trail_ev  = at_edge && !idle_phase;
                last      = stop_idle ||
                            (trail_ev && ((state == ST_DRAIN) || !en ||
                                          ((burst_len_q != '0) && (periods_inc == burst_len_q))));
                if (done) begin
                    state_nx = ST_IDLE;
                end else if ((state == ST_RUN) && !en && !idle_phase && !at_edge) begin
                    state_nx = ST_DRAIN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            clk_cs    <= 1'b0;
            lead_stb  <= 1'b0;
            trail_stb <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            lead_stb  <= lead_ev;
            trail_stb <= trail_ev;
            done      <= last;
            if (state == ST_IDLE) begin
                clk_cs <= cpol;
            end else if (lead_ev || trail_ev) begin
                clk_cs <= ~clk_cs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_half_q  <= '0;
            burst_len_q <= '0;
            cpol_q      <= 1'b0;
        end else if (state == ST_IDLE) begin
            cpol_q <= cpol;
            if (launch) begin
                div_half_q  <= div_half;
                burst_len_q <= burst_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!active || at_edge) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            periods <= '0;
        end else if (state == ST_IDLE) begin
            periods <= '0;
        end else if (trail_ev) begin
            periods <= periods_inc;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus randomized runs
// compared against an arithmetic timeline model of the divided clock.
module tb_clk_div_prog;
    import clk_div_prog_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_cs_en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] div_half = 8'd0;
    logic       cpol = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       clk_cs, lead_stb, trail_stb, busy, done;

    clk_div_prog #(.CNT_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_cs_en (clk_cs_en),
        .start     (start),
        .div_half  (div_half),
        .cpol      (cpol),
        .burst_len (burst_len),
        .clk_cs    (clk_cs),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int obs_trails = 0;

    // Model: edges since start (m_t), half-period length m_h; edge boundaries at multiples of m_h,
    // odd multiples are leading edges and even ones trailing edges.
    bit   m_busy = 0, m_fin = 0, m_en_low = 0, m_cpol = 0;
    int   m_t = 0, m_h = 1, m_bl = 0;
    logic e_clk = 1'b0, e_lead = 1'b0, e_trail = 1'b0, e_done = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit en_s;
        int k;
        en_s    = (clk_cs_en == CLK_CS_ENABLE);
        e_lead  = 1'b0;
        e_trail = 1'b0;
        e_done  = 1'b0;
        if (!m_busy) begin
            e_clk = cpol;
            if (start && en_s) begin
                m_busy   = 1;
                m_t      = 0;
                m_h      = int'(div_half) + 1;
                m_bl     = int'(burst_len);
                m_cpol   = cpol;
                m_en_low = 0;
                m_fin    = 0;
            end
        end else if (m_fin) begin
            m_busy = 0;
        end else begin
            m_t++;
            if (!en_s) m_en_low = 1;
            if (m_t % m_h == 0) begin
                k = m_t / m_h;
                if (k % 2 == 1) begin
                    if (!en_s) begin
                        e_done = 1'b1;
                        m_fin  = 1;
                    end else begin
                        e_lead = 1'b1;
                        e_clk  = ~m_cpol;
                    end
                end else begin
                    e_trail = 1'b1;
                    e_clk   = m_cpol;
                    if (m_en_low || (m_bl != 0 && k / 2 == m_bl)) begin
                        e_done = 1'b1;
                        m_fin  = 1;
                    end
                end
                m_en_low = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        if (trail_stb === 1'b1) obs_trails++;
        chk("clk_cs", clk_cs, e_clk);
        chk("lead_stb", lead_stb, e_lead);
        chk("trail_stb", trail_stb, e_trail);
        chk("done", done, e_done);
        chk("busy", busy, m_busy);
    endtask

    task automatic run_idle(input int limit);
        int i;
        i = 0;
        while (m_busy && i < limit) begin
            cyc();
            i++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic go(input int dh, input int bl, input logic pol);
        div_half  = 8'(dh);
        burst_len = 8'(bl);
        cpol      = pol;
        clk_cs_en = CLK_CS_ENABLE;
        start     = 1'b1;
        cyc();
        start      = 1'b0;
        obs_trails = 0;
    endtask

    task automatic wait_lead(input int limit);
        int w;
        w = 0;
        while (!e_lead && w < limit) begin
            cyc();
            w++;
        end
        chk("lead_timeout", lead_stb, 1'b1);
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();

        // legacy divide-by-4
        go(1, 0, 1'b0);
        repeat (16) cyc();
        chk_int("legacy_periods", obs_trails, 4);
        clk_cs_en = ~CLK_CS_ENABLE;
        run_idle(20);
        repeat (2) cyc();

        // burst of 3 with cpol=1
        go(0, 3, 1'b1);
        n = 0;
        while (m_busy && n < 50) begin
            cyc();
            n++;
        end
        chk_int("burst3_trails", obs_trails, 3);
        chk_int("burst3_cycles", n, 7);

        // start in the done cycle is ignored
        go(1, 2, 1'b0);
        n = 0;
        while (!e_done && n < 50) begin
            cyc();
            n++;
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();

        // glitch-free stop, re-enable during drain does not resume
        go(3, 0, 1'b0);
        wait_lead(20);
        cyc();
        clk_cs_en = ~CLK_CS_ENABLE;
        cyc();
        clk_cs_en = CLK_CS_ENABLE;
        run_idle(40);
        chk_int("drain_trails", obs_trails, 1);
        repeat (4) cyc();

        // ignore rules
        clk_cs_en = ~CLK_CS_ENABLE;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        go(2, 4, 1'b0);
        repeat (5) cyc();
        start     = 1'b1;
        div_half  = 8'd0;
        burst_len = 8'd1;
        cpol      = 1'b1;
        cyc();
        start = 1'b0;
        run_idle(100);
        chk_int("ignore_trails", obs_trails, 4);
        repeat (2) cyc();

        // extremes
        go(255, 1, 1'b0);
        run_idle(600);
        chk_int("dh255_trails", obs_trails, 1);
        go(0, 255, 1'b0);
        run_idle(600);
        chk_int("bl255_trails", obs_trails, 255);
        go(0, 0, 1'b1);
        repeat (600) cyc();
        chk_int("cont300_trails", obs_trails, 300);
        clk_cs_en = ~CLK_CS_ENABLE;
        run_idle(10);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            go($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            n = 0;
            while (m_busy && n < 150) begin
                if ($urandom_range(0, 9) == 0) clk_cs_en = ~clk_cs_en;
                start = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) div_half = 8'($urandom_range(0, 6));
                if ($urandom_range(0, 5) == 0) cpol = ~cpol;
                cyc();
                n++;
            end
            start     = 1'b0;
            clk_cs_en = ~CLK_CS_ENABLE;
            run_idle(40);
            repeat ($urandom_range(1, 3)) cyc();
        end

        // asynchronous reset while clk_cs is high
        go(1, 0, 1'b0);
        wait_lead(10);
        #2 rst = 1'b0;
        #1;
        m_busy = 0;
        m_fin  = 0;
        e_clk  = 1'b0;
        e_lead = 1'b0;
        e_trail = 1'b0;
        e_done = 1'b0;
        chk("async_clk_cs", clk_cs, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 1'b0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
